cfu_simd_acc: RTL and testbench
===============================

Name: cfu_simd_acc

Overview:
- Second-generation CFU on the CPU custom-instruction bus. Keeps the two scalar ops (abs-diff, in1*4+in2) and adds packed-lane SAD and MAC into a persistent accumulator.
- Registered response with full valid/ready backpressure, plus one multi-cycle serial-MAC op.
- Used by TFLite conv/depthwise kernels: one instruction per 32-bit word of packed activations/filters.

Parameters:
- LANE_W, 8, packed lane width in bits; legal values 8 or 16. LANES = 32/LANE_W.
- ACC_W, 32, accumulator width, 16..32. Results are sign-extended to 32 bits on output.
- IN_OFFSET, 128, signed constant added to each in1 lane before the MAC multiply (input zero-point).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- cmd_valid  in  1  command valid
- cmd_ready  out  1  command accepted when cmd_valid&&cmd_ready at rising clk
- cmd_payload_function_id  in  3  opcode
- cmd_payload_inputs_0  in  32  operand in1
- cmd_payload_inputs_1  in  32  operand in2
- rsp_valid  out  1  response valid
- rsp_ready  in  1  CPU ready for response
- rsp_payload_response_ok  out  1  0 = illegal opcode
- rsp_payload_outputs_0  out  32  result

Behaviour:
- One clock (clk); reset synchronous, active-high.
- Reset: rsp_valid=0, rsp_payload_outputs_0=0, rsp_payload_response_ok=1, acc=0, state=IDLE, lane counter=0. cmd_ready=1 in the first cycle after reset deasserts.
- Reset asserted mid-operation aborts MAC_RUN, drops any pending response and clears acc.
- cmd_ready = (state==IDLE) && (!rsp_valid || rsp_ready). A response and a new command may complete in the same cycle.
- Response register holds outputs and rsp_valid stable until rsp_valid&&rsp_ready.
- States:
  - IDLE: accepts commands.
  - MAC_RUN: cmd_ready=0; one lane per cycle.
  - IDLE follows the response write.
- Opcodes. Single-cycle ops: rsp_valid rises the cycle after accept.
  - 0: |in1-in2|, unsigned 32-bit compare. acc unchanged.
  - 1: in1*4+in2, mod 2^32. acc unchanged.
  - 2: SAD. acc += sum over lanes of |a_i-b_i|, with a_i, b_i unsigned LANE_W-bit lanes of in1/in2. Returns new acc.
  - 3: returns acc; acc unchanged.
  - 4: returns old acc; acc := 0.
  - 5: acc := in1[ACC_W-1:0]; returns in1.
  - 6: MAC, multi-cycle.
    - On accept: latch operands, enter MAC_RUN.
    - Each cycle k = 0..LANES-1: acc += (signed a_k + IN_OFFSET) * signed b_k, with lane 0 at bits [LANE_W-1:0].
    - After the last lane: write acc to the response, set rsp_valid, return to IDLE.
    - Accept-to-rsp_valid latency = LANES cycles (4 for LANE_W=8).
  - 7: illegal. rsp_payload_response_ok=0, outputs=0, acc unchanged, latency 1.
- Arithmetic:
  - Lane terms computed at ACC_W+1 bits. acc wraps mod 2^ACC_W (see optional feature).
  - Output = sign-extended acc.
  - SAD sum is added as a non-negative term.
- Boundaries:
  - Back-to-back single-cycle ops with rsp_ready=1 give one result per cycle.
  - While rsp_ready=0 the held response never changes, and no further commands are accepted.
  - A MAC accepted while a prior response is being consumed in the same cycle is legal.

Optional Feature:
- Macro CFU_SIMD_ACC_SAT_EN.
- Defined: every acc update saturates to the signed ACC_W range [-2^(ACC_W-1), 2^(ACC_W-1)-1]. For MAC, saturation is applied per lane step.
- Undefined: two's-complement wrap.
- Opcode 5 loads are never clamped.

Test Plan:
- Reset then op0 with in1=3, in2=10, rsp_ready=1 -> rsp_valid 1 cycle after accept, out=7, ok=1. Op1 with in1=5, in2=2 -> out=22.
- Op4, then op2 with in1=0x0A14_1E28, in2=0x1410_1E32 (LANE_W=8) -> out=10+4+0+10=24. Op3 -> 24.
- Op5 in1=0, then op6 with in1=0xFF80_0001 (lanes -1, -128, 0, 1 → offset to 127, 0, 128, 129), in2=0x0102_0304 -> 127*1+0*2+128*3+129*4 = 1027. rsp_valid exactly 4 cycles after accept; cmd_ready=0 throughout MAC_RUN.
- Hold rsp_ready=0 for 5 cycles after op0 -> rsp_valid stays 1, output stable, cmd_ready=0. Raise rsp_ready with a queued cmd -> handoff and new accept in the same cycle.
- Op7 -> ok=0, out=0, acc unchanged (verify with op3). Assert reset during MAC_RUN cycle 2 -> rsp_valid=0, acc=0, cmd_ready=1 after release.
- Op5 in1=0x7FFF_FFF0, then op2 with lane diffs summing to 0x20 -> CFU_SIMD_ACC_SAT_EN defined: 0x7FFF_FFFF; undefined: 0x8000_0010.

Source files
------------

// File: rtl/cfu_simd_acc_if.sv
// Custom-instruction bus between the CPU (master) and the CFU (slave):
// command channel with valid/ready, registered response channel with valid/ready.
interface cfu_simd_acc_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_payload_function_id;
  logic [31:0] cmd_payload_inputs_0;
  logic [31:0] cmd_payload_inputs_1;
  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_payload_response_ok;
  logic [31:0] rsp_payload_outputs_0;

  modport master (
    output cmd_valid, cmd_payload_function_id, cmd_payload_inputs_0, cmd_payload_inputs_1,
    output rsp_ready,
    input  cmd_ready, rsp_valid, rsp_payload_response_ok, rsp_payload_outputs_0
  );

  modport slave (
    input  cmd_valid, cmd_payload_function_id, cmd_payload_inputs_0, cmd_payload_inputs_1,
    input  rsp_ready,
    output cmd_ready, rsp_valid, rsp_payload_response_ok, rsp_payload_outputs_0
  );
endinterface

// File: rtl/cfu_simd_acc.sv
// SIMD CFU: scalar abs-diff / scale-add, packed SAD, serial per-lane MAC into a persistent accumulator.
// Define CFU_SIMD_ACC_SAT_EN to saturate accumulator updates instead of wrapping.
module cfu_simd_acc #(
  parameter int LANE_W    = 8,
  parameter int ACC_W     = 32,
  parameter int IN_OFFSET = 128
) (
  input logic          clk,
  input logic          reset,
  cfu_simd_acc_if.slave bus
);

  localparam int LANES = 32 / LANE_W;
  localparam int CNT_W = (LANES > 2) ? $clog2(LANES) : 1;
  localparam logic [CNT_W-1:0] LAST_LANE = CNT_W'(LANES - 1);
  localparam logic signed [63:0]    OFF_64  = 64'(IN_OFFSET);
  localparam logic signed [ACC_W:0] OFF_EXT = OFF_64[ACC_W:0];

  typedef enum logic [0:0] {IDLE, MAC_RUN} state_t;

  state_t                   state_q, state_d;
  logic [CNT_W-1:0]         lane_q, lane_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic [31:0]              op_a_q, op_a_d;
  logic [31:0]              op_b_q, op_b_d;
  logic                     rsp_valid_q, rsp_valid_d;
  logic                     rsp_ok_q, rsp_ok_d;
  logic [31:0]              rsp_out_q, rsp_out_d;

  logic                     cmd_ready;
  logic                     cmd_fire;
  logic [LANE_W-1:0]        mac_a, mac_b;
  logic [31:0]              in1, in2;

  // Accumulator update: the sum is formed two bits wider so overflow is visible in the top bits.
  function automatic logic signed [ACC_W-1:0] acc_add(input logic signed [ACC_W-1:0] acc,
                                                      input logic signed [ACC_W:0]   term);
    logic signed [ACC_W+1:0] sum;
    sum = {acc[ACC_W-1], acc[ACC_W-1], acc} + {term[ACC_W], term};
`ifdef CFU_SIMD_ACC_SAT_EN
    if (!sum[ACC_W+1] && (sum[ACC_W:ACC_W-1] != 2'b00))
      return {1'b0, {(ACC_W-1){1'b1}}};
    else if (sum[ACC_W+1] && (sum[ACC_W:ACC_W-1] != 2'b11))
      return {1'b1, {(ACC_W-1){1'b0}}};
    else
      return sum[ACC_W-1:0];
`else
    return sum[ACC_W-1:0];
`endif
  endfunction

  function automatic logic signed [ACC_W:0] sad_term(input logic [31:0] a, input logic [31:0] b);
    logic [ACC_W:0]    sum;
    logic [LANE_W-1:0] x, y, d;
    sum = '0;
    for (int i = 0; i < LANES; i++) begin
      x   = a[i*LANE_W +: LANE_W];
      y   = b[i*LANE_W +: LANE_W];
      d   = (x >= y) ? (x - y) : (y - x);
      sum = sum + {{(ACC_W+1-LANE_W){1'b0}}, d};
    end
    return sum;
  endfunction

  // Activation lane is re-centred by the input zero-point before the signed multiply.
  function automatic logic signed [ACC_W:0] mac_term(input logic [LANE_W-1:0] a,
                                                     input logic [LANE_W-1:0] b);
    logic signed [ACC_W:0] ax, bx;
    ax = {{(ACC_W+1-LANE_W){a[LANE_W-1]}}, a};
    bx = {{(ACC_W+1-LANE_W){b[LANE_W-1]}}, b};
    ax = ax + OFF_EXT;
    return ax * bx;
  endfunction

  function automatic logic [31:0] sext32(input logic signed [ACC_W-1:0] a);
    return 32'(a);
  endfunction

  assign in1       = bus.cmd_payload_inputs_0;
  assign in2       = bus.cmd_payload_inputs_1;
  assign cmd_ready = (state_q == IDLE) && (!rsp_valid_q || bus.rsp_ready);
  assign cmd_fire  = bus.cmd_valid && cmd_ready;

  always_comb begin
    mac_a = '0;
    mac_b = '0;
    for (int i = 0; i < LANES; i++) begin
      if (lane_q == CNT_W'(i)) begin
        mac_a = op_a_q[i*LANE_W +: LANE_W];
        mac_b = op_b_q[i*LANE_W +: LANE_W];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    lane_d      = lane_q;
    acc_d       = acc_q;
    op_a_d      = op_a_q;
    op_b_d      = op_b_q;
    rsp_valid_d = rsp_valid_q;
    rsp_ok_d    = rsp_ok_q;
    rsp_out_d   = rsp_out_q;

    if (rsp_valid_q && bus.rsp_ready)
      rsp_valid_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (cmd_fire) begin
          rsp_valid_d = 1'b1;
          rsp_ok_d    = 1'b1;
          case (bus.cmd_payload_function_id)
            3'd0: rsp_out_d = (in1 >= in2) ? (in1 - in2) : (in2 - in1);
            3'd1: rsp_out_d = {in1[29:0], 2'b00} + in2;
            3'd2: begin
              acc_d     = acc_add(acc_q, sad_term(in1, in2));
              rsp_out_d = sext32(acc_d);
            end
            3'd3: rsp_out_d = sext32(acc_q);
            3'd4: begin
              rsp_out_d = sext32(acc_q);
              acc_d     = '0;
            end
            3'd5: begin
              acc_d     = in1[ACC_W-1:0];
              rsp_out_d = in1;
            end
            3'd6: begin
              rsp_valid_d = 1'b0;
              op_a_d      = in1;
              op_b_d      = in2;
              lane_d      = '0;
              state_d     = MAC_RUN;
            end
            default: begin
              rsp_ok_d  = 1'b0;
              rsp_out_d = '0;
            end
          endcase
        end
      end
      MAC_RUN: begin
        acc_d  = acc_add(acc_q, mac_term(mac_a, mac_b));
        lane_d = lane_q + 1'b1;
        if (lane_q == LAST_LANE) begin
          lane_d      = '0;
          state_d     = IDLE;
          rsp_valid_d = 1'b1;
          rsp_ok_d    = 1'b1;
          rsp_out_d   = sext32(acc_d);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      lane_q      <= '0;
      acc_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_ok_q    <= 1'b1;
      rsp_out_q   <= '0;
    end else begin
      state_q     <= state_d;
      lane_q      <= lane_d;
      acc_q       <= acc_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_ok_q    <= rsp_ok_d;
      rsp_out_q   <= rsp_out_d;
    end
  end

  // Operand latches are only meaningful in MAC_RUN, so they carry no reset.
  always_ff @(posedge clk) begin
    op_a_q <= op_a_d;
    op_b_q <= op_b_d;
  end

  assign bus.cmd_ready               = cmd_ready;
  assign bus.rsp_valid               = rsp_valid_q;
  assign bus.rsp_payload_response_ok = rsp_ok_q;
  assign bus.rsp_payload_outputs_0   = rsp_out_q;

endmodule

// File: tb/tb_cfu_simd_acc.sv
// Directed bench for cfu_simd_acc (LANE_W=8, ACC_W=32, IN_OFFSET=128).
module tb_cfu_simd_acc;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  cfu_simd_acc_if bus();

  cfu_simd_acc #(.LANE_W(8), .ACC_W(32), .IN_OFFSET(128)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [2:0]  fid;
    logic [31:0] in1;
    logic [31:0] in2;
    logic [31:0] exp_out;
    logic        exp_ok;
  } vec_t;

  localparam logic [31:0] SAT_EXP =
`ifdef CFU_SIMD_ACC_SAT_EN
    32'h7FFF_FFFF;
`else
    32'h8000_0010;
`endif

  int   n_checks = 0;
  int   n_fail   = 0;
  vec_t vecs[$];

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  // Called just after a falling edge; returns just after the falling edge following acceptance.
  task automatic issue(input logic [2:0] fid, input logic [31:0] a, input logic [31:0] b);
    bit done;
    done = 1'b0;
    bus.cmd_valid               = 1'b1;
    bus.cmd_payload_function_id = fid;
    bus.cmd_payload_inputs_0    = a;
    bus.cmd_payload_inputs_1    = b;
    #1;
    for (int i = 0; i < 20 && !done; i++) begin
      if (bus.cmd_ready) begin
        @(posedge clk);
        done = 1'b1;
      end else begin
        @(negedge clk);
        #1;
      end
    end
    if (!done) begin
      n_checks++;
      n_fail++;
      $display("FAIL accept_timeout: op %0d not accepted within 20 cycles", fid);
    end
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    #1;
  endtask

  task automatic run(input string name, input logic [2:0] fid, input logic [31:0] a,
                     input logic [31:0] b, input logic [31:0] exp_out, input logic exp_ok);
    issue(fid, a, b);
    check1({name, "_valid"}, bus.rsp_valid, 1'b1);
    check32({name, "_out"}, bus.rsp_payload_outputs_0, exp_out);
    check1({name, "_ok"}, bus.rsp_payload_response_ok, exp_ok);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d failures so far", n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    reset                       = 1'b1;
    bus.cmd_valid               = 1'b0;
    bus.cmd_payload_function_id = 3'd0;
    bus.cmd_payload_inputs_0    = '0;
    bus.cmd_payload_inputs_1    = '0;
    bus.rsp_ready               = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check1("reset_rsp_valid", bus.rsp_valid, 1'b0);
    check32("reset_out", bus.rsp_payload_outputs_0, 32'h0);
    check1("reset_ok", bus.rsp_payload_response_ok, 1'b1);
    check1("reset_cmd_ready", bus.cmd_ready, 1'b1);

    vecs.push_back('{3'd0, 32'd3,          32'd10,         32'd7,          1'b1});
    vecs.push_back('{3'd1, 32'd5,          32'd2,          32'd22,         1'b1});
    vecs.push_back('{3'd4, 32'd0,          32'd0,          32'd0,          1'b1});
    vecs.push_back('{3'd2, 32'h0A14_1E28,  32'h1410_1E32,  32'd24,         1'b1});
    vecs.push_back('{3'd3, 32'd0,          32'd0,          32'd24,         1'b1});
    vecs.push_back('{3'd7, 32'hDEAD_BEEF,  32'h1234_5678,  32'd0,          1'b0});
    vecs.push_back('{3'd3, 32'd0,          32'd0,          32'd24,         1'b1});
    vecs.push_back('{3'd0, 32'd10,         32'd3,          32'd7,          1'b1});
    vecs.push_back('{3'd0, 32'd0,          32'hFFFF_FFFF,  32'hFFFF_FFFF,  1'b1});
    vecs.push_back('{3'd1, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFD,  1'b1});
    vecs.push_back('{3'd2, 32'hFF00_FF00,  32'h00FF_00FF,  32'h0000_0414,  1'b1});
    vecs.push_back('{3'd4, 32'd0,          32'd0,          32'h0000_0414,  1'b1});
    vecs.push_back('{3'd3, 32'd0,          32'd0,          32'd0,          1'b1});
    vecs.push_back('{3'd5, 32'hFFFF_FFF0,  32'd0,          32'hFFFF_FFF0,  1'b1});
    vecs.push_back('{3'd3, 32'd0,          32'd0,          32'hFFFF_FFF0,  1'b1});
    vecs.push_back('{3'd5, 32'd0,          32'd0,          32'd0,          1'b1});

    foreach (vecs[i])
      run($sformatf("vec%0d", i), vecs[i].fid, vecs[i].in1, vecs[i].in2,
          vecs[i].exp_out, vecs[i].exp_ok);

    // MAC: lanes (1,0,-128,-1)+128 times (4,3,2,1) = 1027, four cycles after accept.
    issue(3'd6, 32'hFF80_0001, 32'h0102_0304);
    for (int k = 0; k < 4; k++) begin
      check1($sformatf("mac_busy_ready_c%0d", k), bus.cmd_ready, 1'b0);
      check1($sformatf("mac_busy_valid_c%0d", k), bus.rsp_valid, 1'b0);
      @(negedge clk);
      #1;
    end
    check1("mac_valid", bus.rsp_valid, 1'b1);
    check32("mac_out", bus.rsp_payload_outputs_0, 32'd1027);

    // Second MAC accepted in the same cycle the first response is consumed: +4*128.
    issue(3'd6, 32'h0000_0000, 32'h0101_0101);
    repeat (3) @(negedge clk);
    #1;
    check1("mac2_early_valid", bus.rsp_valid, 1'b0);
    @(negedge clk);
    #1;
    check1("mac2_valid", bus.rsp_valid, 1'b1);
    check32("mac2_out", bus.rsp_payload_outputs_0, 32'd1539);
    @(negedge clk);
    #1;

    // Backpressure: held response, queued command hands off on the release edge.
    bus.rsp_ready = 1'b0;
    issue(3'd0, 32'd5, 32'd1);
    bus.cmd_valid               = 1'b1;
    bus.cmd_payload_function_id = 3'd1;
    bus.cmd_payload_inputs_0    = 32'd1;
    bus.cmd_payload_inputs_1    = 32'd1;
    for (int k = 0; k < 5; k++) begin
      #1;
      check1($sformatf("hold_valid_c%0d", k), bus.rsp_valid, 1'b1);
      check32($sformatf("hold_out_c%0d", k), bus.rsp_payload_outputs_0, 32'd4);
      check1($sformatf("hold_ready_c%0d", k), bus.cmd_ready, 1'b0);
      @(negedge clk);
    end
    bus.rsp_ready = 1'b1;
    #1;
    check1("handoff_cmd_ready", bus.cmd_ready, 1'b1);
    @(posedge clk);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    #1;
    check1("handoff_valid", bus.rsp_valid, 1'b1);
    check32("handoff_out", bus.rsp_payload_outputs_0, 32'd5);

    // Reset in the middle of a MAC aborts it and clears the accumulator.
    run("preload", 3'd5, 32'd100, 32'd0, 32'd100, 1'b1);
    issue(3'd6, 32'h0101_0101, 32'h0101_0101);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check1("abort_rsp_valid", bus.rsp_valid, 1'b0);
    check1("abort_cmd_ready", bus.cmd_ready, 1'b1);
    check32("abort_out", bus.rsp_payload_outputs_0, 32'd0);
    check1("abort_ok", bus.rsp_payload_response_ok, 1'b1);
    repeat (5) @(negedge clk);
    #1;
    check1("abort_no_late_rsp", bus.rsp_valid, 1'b0);
    run("abort_acc", 3'd3, 32'd0, 32'd0, 32'd0, 1'b1);

    // Accumulator overflow on SAD: saturates or wraps depending on build.
    run("sat_load", 3'd5, 32'h7FFF_FFF0, 32'd0, 32'h7FFF_FFF0, 1'b1);
    run("sat_sad", 3'd2, 32'h0000_0020, 32'h0000_0000, SAT_EXP, 1'b1);
    run("sat_read", 3'd3, 32'd0, 32'd0, SAT_EXP, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
